tdp_ram_prio: RTL and testbench

- Parametrised true-dual-port synchronous RAM. Next generation of the team's priority dual-port memory test blocks.
- Adds byte-lane write enables and a per-port read-during-write mode.
- Adds a configurable cross-port collision priority, an optional output pipeline register, and a reset-triggered memory-clear sweep with a busy flag.
- Used as a RAM-inference target for block/huge RAM mapping tests, and as a generic on-chip buffer.

---
 rtl/tdp_ram_prio.sv | 203 ++++++++++++++++++++
 tb/tb_tdp_ram_prio.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdp_ram_prio.sv
// True-dual-port RAM with byte lanes, per-port read-during-write modes, cross-port priority and a clear sweep.
// Optional collision counter output coll_cnt enabled by `define TDP_RAM_PRIO_COLLISION_CNT_EN.
module tdp_ram_prio #(
    parameter int ABITS        = 10,
    parameter int WIDTH        = 72,
    parameter int BYTE_W       = 9,
    parameter int MODE_A       = 0,
    parameter int MODE_B       = 0,
    parameter int PRIO_B       = 0,
    parameter int XBYPASS      = 1,
    parameter int OUT_REG      = 0,
    parameter int CLEAR_ON_RST = 1,
    localparam int NB          = WIDTH / BYTE_W
) (
`ifdef TDP_RAM_PRIO_COLLISION_CNT_EN
    output logic [15:0]      coll_cnt,
`endif
    input  logic             clk,
    input  logic             rst,
    output logic             busy,
    input  logic             en_a,
    input  logic [NB-1:0]    we_a,
    input  logic [ABITS-1:0] addr_a,
    input  logic [WIDTH-1:0] wdata_a,
    output logic [WIDTH-1:0] rdata_a,
    output logic             rvalid_a,
    input  logic             en_b,
    input  logic [NB-1:0]    we_b,
    input  logic [ABITS-1:0] addr_b,
    input  logic [WIDTH-1:0] wdata_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_b
);
    localparam int DEPTH = 2 ** ABITS;
    localparam logic [ABITS-1:0] PTR_ONE  = {{(ABITS-1){1'b0}}, 1'b1};
    localparam logic [ABITS-1:0] PTR_LAST = {ABITS{1'b1}};

    typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} state_t;

    state_t           state, state_nx;
    logic [ABITS-1:0] ptr, ptr_nx;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             act_a, act_b, same, rd_a, rd_b;
    logic [NB-1:0]    wl_a, wl_b;
    logic [WIDTH-1:0] rword_a, rword_b;
    logic [WIDTH-1:0] s1_data_a, s1_data_b;
    logic             s1_valid_a, s1_valid_b;

    // Lanes the other port writes at the same address are either bypassed or read from the old word.
    function automatic logic [WIDTH-1:0] rd_word(
        input logic [WIDTH-1:0] old,
        input logic [NB-1:0]    own_we,
        input logic [WIDTH-1:0] own_wd,
        input logic [NB-1:0]    oth_we,
        input logic [WIDTH-1:0] oth_wd,
        input logic             own_wins,
        input int               mode
    );
        logic [WIDTH-1:0] r;
        r = old;
        for (int i = 0; i < NB; i++) begin
            if (oth_we[i] && (XBYPASS != 0)) begin
                r[i*BYTE_W +: BYTE_W] = (own_we[i] && own_wins) ? own_wd[i*BYTE_W +: BYTE_W]
                                                                : oth_wd[i*BYTE_W +: BYTE_W];
            end else if (oth_we[i]) begin
                r[i*BYTE_W +: BYTE_W] = old[i*BYTE_W +: BYTE_W];
            end else if (own_we[i] && (mode == 1)) begin
                r[i*BYTE_W +: BYTE_W] = own_wd[i*BYTE_W +: BYTE_W];
            end else begin
                r[i*BYTE_W +: BYTE_W] = old[i*BYTE_W +: BYTE_W];
            end
        end
        return r;
    endfunction

    // Sweep sequencing: CLEAR walks every address once, then RUN.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        case (state)
            CLEAR: begin
                ptr_nx = ptr + PTR_ONE;
                if (ptr == PTR_LAST) begin
                    state_nx = RUN;
                end else begin
                    state_nx = CLEAR;
                end
            end
            RUN: begin
                state_nx = RUN;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

    // State, pointer and busy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLEAR_ON_RST != 0) ? CLEAR : RUN;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            busy  <= (state_nx == CLEAR);
        end
    end

    // Request qualification and read-word formation.
    always_comb begin
        act_a   = en_a & ~busy & ~rst;
        act_b   = en_b & ~busy & ~rst;
        wl_a    = act_a ? we_a : '0;
        wl_b    = act_b ? we_b : '0;
        same    = act_a & act_b & (addr_a == addr_b);
        rd_a    = act_a & ~((MODE_A == 2) & (|we_a));
        rd_b    = act_b & ~((MODE_B == 2) & (|we_b));
        rword_a = rd_word(mem[addr_a], wl_a, wdata_a, same ? wl_b : '0, wdata_b,
                          (PRIO_B == 0), MODE_A);
        rword_b = rd_word(mem[addr_b], wl_b, wdata_b, same ? wl_a : '0, wdata_a,
                          (PRIO_B != 0), MODE_B);
    end

    // Memory array: sweep zeroing, or per-lane writes with the losing port masked on overlap.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wl_a[i] && !(same && wl_b[i] && (PRIO_B != 0))) begin
                    mem[addr_a][i*BYTE_W +: BYTE_W] <= wdata_a[i*BYTE_W +: BYTE_W];
                end
                if (wl_b[i] && !(same && wl_a[i] && (PRIO_B == 0))) begin
                    mem[addr_b][i*BYTE_W +: BYTE_W] <= wdata_b[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // First read stage; data holds when no read completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_a <= 1'b0;
            s1_valid_b <= 1'b0;
            s1_data_a  <= '0;
            s1_data_b  <= '0;
        end else begin
            s1_valid_a <= rd_a;
            s1_valid_b <= rd_b;
            if (rd_a) begin
                s1_data_a <= rword_a;
            end
            if (rd_b) begin
                s1_data_b <= rword_b;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            // Optional second stage for latency 2.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_a <= 1'b0;
                    rvalid_b <= 1'b0;
                    rdata_a  <= '0;
                    rdata_b  <= '0;
                end else begin
                    rvalid_a <= s1_valid_a;
                    rvalid_b <= s1_valid_b;
                    if (s1_valid_a) begin
                        rdata_a <= s1_data_a;
                    end
                    if (s1_valid_b) begin
                        rdata_b <= s1_data_b;
                    end
                end
            end
        end else begin : g_noreg
            assign rvalid_a = s1_valid_a;
            assign rvalid_b = s1_valid_b;
            assign rdata_a  = s1_data_a;
            assign rdata_b  = s1_data_b;
        end
    endgenerate

`ifdef TDP_RAM_PRIO_COLLISION_CNT_EN
    // Saturating count of same-address cycles where at least one port writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_cnt <= 16'h0000;
        end else if (same && ((|wl_a) || (|wl_b)) && (coll_cnt != 16'hFFFF)) begin
            coll_cnt <= coll_cnt + 16'h0001;
        end else begin
            coll_cnt <= coll_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_tdp_ram_prio.sv
// Scoreboard bench: two differently configured instances share one randomized stimulus stream.
module tb_tdp_ram_prio;
    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b;
    logic [7:0]  we_a, we_b;
    logic [3:0]  addr_a, addr_b;
    logic [71:0] wdata_a, wdata_b;
    logic        busy0, busy1;
    logic [71:0] rd0a, rd0b, rd1a, rd1b;
    logic        rv0a, rv0b, rv1a, rv1b;

    always #5 clk = ~clk;

    tdp_ram_prio #(.ABITS(4), .WIDTH(72), .BYTE_W(9), .MODE_A(0), .MODE_B(1), .PRIO_B(0),
                   .XBYPASS(1), .OUT_REG(0), .CLEAR_ON_RST(1)) dut0 (
        .clk(clk), .rst(rst), .busy(busy0),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .rdata_a(rd0a), .rvalid_a(rv0a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .rdata_b(rd0b), .rvalid_b(rv0b));

    tdp_ram_prio #(.ABITS(4), .WIDTH(72), .BYTE_W(9), .MODE_A(1), .MODE_B(2), .PRIO_B(1),
                   .XBYPASS(0), .OUT_REG(1), .CLEAR_ON_RST(1)) dut1 (
        .clk(clk), .rst(rst), .busy(busy1),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .rdata_a(rd1a), .rvalid_a(rv1a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .rdata_b(rd1b), .rvalid_b(rv1b));

    // Configuration of each instance as seen by the reference model.
    int cf_mode_a [2] = '{0, 1};
    int cf_mode_b [2] = '{1, 2};
    int cf_prio   [2] = '{0, 1};
    int cf_xb     [2] = '{1, 0};
    int cf_lat    [2] = '{1, 2};

    typedef struct packed {
        logic [71:0] data;
        logic [31:0] due;
    } exp_t;

    exp_t        q [4][$];
    logic [71:0] last [4];
    logic [71:0] m [2][16];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic        mon_rv;
    logic [71:0] mon_rd;
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [71:0] lanes(input logic [7:0] we);
        logic [71:0] r;
        for (int i = 0; i < 8; i++) r[i*9 +: 9] = {9{we[i]}};
        return r;
    endfunction

    function automatic logic [71:0] rnd72();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[71:0];
    endfunction

    // Drive one request cycle, update the model memories and queue the expected reads.
    task automatic step(input logic ea, input logic [7:0] wa, input logic [3:0] aa, input logic [71:0] da,
                        input logic eb, input logic [7:0] wb, input logic [3:0] ab, input logic [71:0] db);
        en_a = ea; we_a = wa; addr_a = aa; wdata_a = da;
        en_b = eb; we_b = wb; addr_b = ab; wdata_b = db;
        for (int d = 0; d < 2; d++) begin
            logic [71:0] oa, ob, ma, mb, ov, win, ra, rb;
            bit same;
            oa   = m[d][aa];
            ob   = m[d][ab];
            ma   = ea ? lanes(wa) : 72'd0;
            mb   = eb ? lanes(wb) : 72'd0;
            same = ea && eb && (aa == ab);
            if (ea) m[d][aa] = (oa & ~ma) | (da & ma);
            if (eb) m[d][ab] = (m[d][ab] & ~mb) | (db & mb);
            if (same) begin
                ov  = ma & mb;
                win = (cf_prio[d] != 0) ? db : da;
                m[d][aa] = (m[d][aa] & ~ov) | (win & ov);
            end
            if (ea && !(cf_mode_a[d] == 2 && wa != 8'd0)) begin
                ra = oa;
                if (cf_mode_a[d] == 1) ra = (ra & ~ma) | (da & ma);
                if (same) ra = (ra & ~mb) | (((cf_xb[d] != 0) ? m[d][aa] : oa) & mb);
                q[2*d].push_back('{data: ra, due: cyc + cf_lat[d]});
            end
            if (eb && !(cf_mode_b[d] == 2 && wb != 8'd0)) begin
                rb = ob;
                if (cf_mode_b[d] == 1) rb = (rb & ~mb) | (db & mb);
                if (same) rb = (rb & ~ma) | (((cf_xb[d] != 0) ? m[d][ab] : ob) & ma);
                q[2*d+1].push_back('{data: rb, due: cyc + cf_lat[d]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 8'd0, 4'd0, 72'd0, 1'b0, 8'd0, 4'd0, 72'd0);
    endtask

    // One reset cycle, then measure the sweep length on both instances.
    task automatic do_reset();
        int cnt;
        int guard;
        rst = 1'b1;
        en_a = 1'b0; en_b = 1'b0; we_a = 8'd0; we_b = 8'd0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            last[k] = 72'd0;
        end
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 16; a++) m[d][a] = 72'd0;
        mon_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy: got busy0=%b busy1=%b, required 1 1", busy0, busy1);
        end
        cnt = 0;
        guard = 0;
        while (busy0 === 1'b1 && guard < 100) begin
            cnt++;
            guard++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 16 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL sweep_len: got %0d busy cycles (busy1=%b), required 16 (busy1=0)", cnt, busy1);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every rvalid, check hold value and latency otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 4; k++) begin
                case (k)
                    0:       begin mon_rv = rv0a; mon_rd = rd0a; end
                    1:       begin mon_rv = rv0b; mon_rd = rd0b; end
                    2:       begin mon_rv = rv1a; mon_rd = rd1a; end
                    default: begin mon_rv = rv1b; mon_rd = rd1b; end
                endcase
                checks++;
                if (mon_rv === 1'b1) begin
                    if (q[k].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rvalid port%0d: got rvalid=1 data=%h, required no read", k, mon_rd);
                    end else begin
                        mon_e = q[k].pop_front();
                        if (mon_rd !== mon_e.data || cyc != int'(mon_e.due)) begin
                            errors++;
                            $display("FAIL read port%0d: got %h at cycle %0d, required %h at cycle %0d",
                                     k, mon_rd, cyc, mon_e.data, mon_e.due);
                        end
                        last[k] = mon_e.data;
                    end
                end else begin
                    if (mon_rv !== 1'b0 || mon_rd !== last[k]) begin
                        errors++;
                        $display("FAIL hold port%0d: got rvalid=%b data=%h, required 0 %h", k, mon_rv, mon_rd, last[k]);
                    end
                    if (q[k].size() != 0) begin
                        checks++;
                        if (int'(q[k][0].due) <= cyc) begin
                            errors++;
                            $display("FAIL missing_rvalid port%0d: got none at cycle %0d, required %h", k, cyc, q[k][0].data);
                            mon_e = q[k].pop_front();
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        en_a = 1'b0; en_b = 1'b0; we_a = 8'd0; we_b = 8'd0;
        addr_a = 4'd0; addr_b = 4'd0; wdata_a = 72'd0; wdata_b = 72'd0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Cleared contents on both ports.
        for (int a = 0; a < 16; a++)
            step(1'b1, 8'd0, 4'(a), 72'd0, 1'b1, 8'd0, 4'(15 - a), 72'd0);

        // Byte-lane write.
        step(1'b1, 8'hFF, 4'd5, {72{1'b1}}, 1'b0, 8'd0, 4'd0, 72'd0);
        step(1'b1, 8'h01, 4'd5, 72'd0, 1'b0, 8'd0, 4'd0, 72'd0);
        step(1'b1, 8'h00, 4'd5, 72'd0, 1'b0, 8'd0, 4'd0, 72'd0);

        // Read-during-write on both ports.
        step(1'b1, 8'hFF, 4'd3, 72'h11, 1'b0, 8'd0, 4'd0, 72'd0);
        step(1'b1, 8'hFF, 4'd3, 72'h22, 1'b0, 8'd0, 4'd0, 72'd0);
        step(1'b0, 8'd0, 4'd0, 72'd0, 1'b1, 8'hFF, 4'd3, 72'h33);
        step(1'b1, 8'h00, 4'd3, 72'd0, 1'b1, 8'h00, 4'd3, 72'd0);

        // Write-write collision, then readback.
        step(1'b1, 8'hFF, 4'd7, 72'hAA, 1'b1, 8'hFF, 4'd7, 72'hBB);
        step(1'b1, 8'h00, 4'd7, 72'd0, 1'b0, 8'd0, 4'd0, 72'd0);

        // Cross-port bypass.
        step(1'b1, 8'hFF, 4'd9, 72'h01, 1'b0, 8'd0, 4'd0, 72'd0);
        step(1'b1, 8'hFF, 4'd9, 72'h55, 1'b1, 8'h00, 4'd9, 72'd0);
        step(1'b0, 8'd0, 4'd0, 72'd0, 1'b1, 8'h00, 4'd9, 72'd0);
        idle();

        // Reset while a read is in flight.
        step(1'b1, 8'h00, 4'd9, 72'd0, 1'b1, 8'h00, 4'd3, 72'd0);
        do_reset();

        // Randomized traffic on a narrow address window to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] wa, wb;
            wa = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            wb = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            step(1'($urandom_range(0, 1)), wa, 4'($urandom_range(0, 3)), rnd72(),
                 1'($urandom_range(0, 1)), wb, 4'($urandom_range(0, 3)), rnd72());
        end
        repeat (4) idle();

        for (int k = 0; k < 4; k++) begin
            checks++;
            if (q[k].size() != 0) begin
                errors++;
                $display("FAIL drain port%0d: got %0d outstanding reads, required 0", k, q[k].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
